// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver with mid-bit sampling, framing-error detection and a byte FIFO
module uart_rx_deframer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       rxd_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic        rx_s, push, pop, empty, full;

    assign rx_s = sync_q[1];
    assign empty = wptr_q == rptr_q;
    assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop = !empty && byte_ready_i;
    assign byte_valid_o = !empty;
    assign byte_data_o = mem_q[rptr_q[AW-1:0]];
    assign busy_o = state_q != IDLE;

    // Two-flop synchronizer, preset to idle-high so reset never looks like a start bit
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) sync_q <= 2'b11;
        else           sync_q <= {sync_q[0], rxd_i};
    end

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Frame decoding; a pop in the same cycle frees a slot for the stop-bit push
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_o = 1'b0;
        overflow_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = FULL_M1;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d[idx_q] = rx_s;
                    cnt_d          = FULL_M1;
                    idx_d          = idx_q + 3'd1;
                    state_d        = (idx_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s) begin
                    push       = !full || pop;
                    overflow_o = full && !pop;
                    state_d    = IDLE;
                end else begin
                    frame_err_o = 1'b1;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte FIFO storage and pointers; the extra pointer MSB separates full from empty
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) mem_q[wptr_q[AW-1:0]] <= shreg_q;
            wptr_q <= wptr_q + PW'(push);
            rptr_q <= rptr_q + PW'(pop);
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized frame stimulus checked against a queue-based model of the receiver
module tb_uart_rx_deframer;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int DECIDE = 154;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid, frame_err, overflow, busy;

    int n_chk = 0, n_pass = 0;
    int ferr_seen = 0, ovf_seen = 0, ferr_exp = 0, ovf_exp = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock_i     (clk),
        .resetn_i    (resetn),
        .rxd_i       (rxd),
        .byte_data_o (byte_data),
        .byte_valid_o(byte_valid),
        .byte_ready_i(byte_ready),
        .frame_err_o (frame_err),
        .overflow_o  (overflow),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input int obs, input int want);
        n_chk++;
        if (obs == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    endtask

    // Pulse counting and popped-byte scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_err) ferr_seen++;
        if (overflow) ovf_seen++;
        if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", int'(byte_data), -1);
            else check("pop_data", int'(byte_data), int'(exp_q.pop_front()));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One frame; per is the bit period in hundredths of a clock. The receiver decides on
    // the stop bit during line cycle DECIDE counted from the start-bit edge.
    task automatic send(input logic [7:0] d, input logic stop, input int per,
                        input int rdy_at, input int rst_at);
        int total;
        total = (10 * per + 99) / 100;
        for (int c = 0; c < total; c++) begin
            int b;
            b = (c * 100) / per;
            rxd = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : stop;
            if (rdy_at >= 0 && c == rdy_at) byte_ready = 1'b1;
            if (rdy_at >= 0 && c == rdy_at + 1) byte_ready = 1'b0;
            if (rst_at >= 0 && c == rst_at) begin
                resetn = 1'b0;
                exp_q.delete();
                #1;
                check("rst_valid", byte_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_data", byte_data, 0);
                check("rst_pulses", {frame_err, overflow}, 0);
            end
            if (rst_at >= 0 && c == rst_at + 1) resetn = 1'b1;
            if (c == DECIDE && rst_at < 0) begin
                if (!stop) ferr_exp++;
                else if (exp_q.size() - ((byte_ready && exp_q.size() > 0) ? 1 : 0) >= DEPTH) ovf_exp++;
                else exp_q.push_back(d);
            end
            cycle();
        end
    endtask

    task automatic drain();
        byte_ready = 1'b1;
        repeat (DEPTH + 4) cycle();
        byte_ready = 1'b0;
    endtask

    initial begin
        repeat (3) cycle();
        check("reset_valid", byte_valid, 0);
        check("reset_data", byte_data, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overflow", overflow, 0);
        resetn = 1'b1;
        repeat (3) cycle();

        send(8'h55, 1'b1, 1600, -1, -1);
        check("valid_after_55", byte_valid, 1);
        check("busy_after_55", busy, 0);
        send(8'hA3, 1'b1, 1600, -1, -1);
        check("busy_after_a3", busy, 0);
        drain();
        check("drained_1", byte_valid, 0);
        check("model_empty_1", exp_q.size(), 0);

        rxd = 1'b0;
        repeat (5) cycle();
        check("glitch_busy", busy, 1);
        rxd = 1'b1;
        repeat (20) cycle();
        check("glitch_idle", busy, 0);
        check("glitch_no_byte", byte_valid, 0);

        send(8'h41, 1'b0, 1600, -1, -1);
        repeat (40) cycle();
        check("break_busy", busy, 1);
        check("break_no_byte", byte_valid, 0);
        check("break_ferr_count", ferr_seen, 1);
        rxd = 1'b1;
        repeat (4) cycle();
        check("break_released", busy, 0);
        send(8'h42, 1'b1, 1600, -1, -1);
        drain();
        check("model_empty_2", exp_q.size(), 0);

        for (int i = 0; i < 9; i++) send(8'(i), 1'b1, 1600, -1, -1);
        check("ovf_count", ovf_seen, 1);
        check("ovf_model", ovf_exp, 1);
        check("ovf_fifo_held", exp_q.size(), DEPTH);
        drain();
        check("ovf_drained", byte_valid, 0);
        check("model_empty_3", exp_q.size(), 0);

        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b1, 1600, -1, -1);
        send(8'($urandom), 1'b1, 1600, DECIDE, -1);
        check("full_pop_no_ovf", ovf_seen, 1);
        check("full_pop_count", exp_q.size(), DEPTH);
        drain();
        check("model_empty_4", exp_q.size(), 0);

        send(8'h11, 1'b1, 1600, -1, -1);
        send(8'hF3, 1'b1, 1600, -1, 85);
        check("post_reset_empty", byte_valid, 0);
        send(8'h7E, 1'b1, 1600, -1, -1);
        check("got_7e", exp_q.size(), 1);
        drain();
        check("model_empty_5", exp_q.size(), 0);

        for (int i = 0; i < 16; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            byte_ready = 1'($urandom_range(0, 1));
            send(8'($urandom), 1'b1, (sel == 0) ? 1552 : (sel == 1) ? 1600 : 1648, -1, -1);
        end
        drain();
        check("final_ovf", ovf_seen, ovf_exp);
        check("final_ferr", ferr_seen, ferr_exp);
        check("final_empty", byte_valid, 0);
        check("model_empty_6", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Synthesizable 8N1 UART receiver that decodes the serial stream driven on the SoC's externalPins_uart_tx line.
- Recovers bytes by mid-bit sampling and detects framing errors.
- Buffers received bytes in a small FIFO with a valid/ready output port.
- Used as the host-side/console end of the SoC UART, both on FPGA, where it feeds a debug byte sink, and in simulation, where it converts the console stream into bytes for the bench.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..64.

Ports:
- clock  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input; idle high; asynchronous to clock.
- byte_data  out  8  head-of-FIFO byte.
- byte_valid  out  1  FIFO non-empty.
- byte_ready  in  1  consumer accepts; pop when byte_valid && byte_ready.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty, state IDLE, counters 0.
  - Synchronizer flops preset to 1 (line idle).
- Input conditioning:
  - rxd passes through a 2-flop synchronizer to produce rx_s.
  - All decisions use rx_s.
  - Fixed latency of 2 cycles from pin to rx_s.
- State machine (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: when rx_s = 0, load bit_cnt_clk = CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: count down to 0, then resample.
    - rx_s = 1: false start; return to IDLE with no output.
    - rx_s = 0: reload the counter with CLKS_PER_BIT-1, set bit_idx = 0, go to DATA.
  - DATA: at each counter expiry, shift rx_s into shreg[bit_idx], LSB first, and reload the counter.
    - After bit_idx = 7 is sampled, go to STOP.
  - STOP: at counter expiry, sample rx_s.
    - 1: byte good. Push it if the FIFO is not full, else pulse overflow. Go to IDLE.
    - 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s = 1, then go to IDLE. This prevents break conditions from generating bytes.
- Sample timing: data bit k is sampled CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT cycles after the rx_s falling edge, ±0 cycles.
- Push timing: a good byte is pushed on the same cycle as the stop-bit sample. byte_valid rises on the next cycle.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap-around via the extra MSB.
  - byte_data is registered from the read pointer and valid whenever byte_valid = 1.
- Simultaneous push and pop when full: the pop frees the slot, so the push is accepted and no overflow is raised.
- Simultaneous push and pop when empty: the pushed byte appears next cycle; there is no fall-through.
- A pop while byte_valid = 0 is ignored.
- Back-to-back frames: a new start bit detected in IDLE on the cycle after STOP is accepted. The receiver therefore tolerates transmitter stop bits down to half a bit period.
- Reset mid-frame: all state clears immediately. The partial byte is lost and the FIFO is emptied.

Test Plan:
- Send 0x55, then 0xA3, at exactly CLKS_PER_BIT=16, FIFO_DEPTH=8 -> byte_valid rises; pops yield 0x55 then 0xA3. frame_err and overflow stay 0. busy falls after each stop bit.
- Pull rxd low for 5 clocks, then high (glitch shorter than a half-bit of 8) -> returns to IDLE; no byte, no frame_err.
- Send 0x41 with the stop bit driven 0, then hold the line low for 40 clocks -> one frame_err pulse; FIFO stays empty; no byte appears until the line is high again. A following 0x42 is then received correctly.
- With byte_ready=0, send 9 bytes 0x00..0x08 -> FIFO holds 0x00..0x07. overflow pulses exactly once, for 0x08. Draining yields 8 bytes in order, and byte_valid then drops.
- With FIFO full, assert byte_ready on the exact cycle of a stop-bit sample -> no overflow; the new byte is stored; the sequence order is preserved.
- Assert resetn=0 for 1 cycle during bit 4 of a frame -> all outputs 0 and FIFO empty. A subsequent clean frame 0x7E is received correctly.
- Transmit at +3% and -3% bit period -> all bytes decoded correctly.
